// File: rtl/hour_counter_if.sv
// Handshake bundle between the minutes-tens stage / adjust switches and the hours stage.
// The pm signal exists only when HOUR_12_EN is defined.
interface hour_counter_if;
    // Valid/ready semantics: there is no backpressure. carry is a one-cycle pulse
    // sampled on every rising edge, adjust is a level sampled every edge, and all
    // outputs are registered and valid in every cycle after reset.
    logic       carry;
    logic       adjust;
    logic [1:0] in_tens;
    logic [3:0] in_units;
    logic [1:0] tens;
    logic [3:0] units;
    logic       day_en;
    logic       load_err;
`ifdef HOUR_12_EN
    logic       pm;
`endif

    modport master (
        output carry, adjust, in_tens, in_units,
`ifdef HOUR_12_EN
        input  pm,
`endif
        input  tens, units, day_en, load_err
    );

    modport slave (
        input  carry, adjust, in_tens, in_units,
`ifdef HOUR_12_EN
        output pm,
`endif
        output tens, units, day_en, load_err
    );
endinterface

// File: rtl/hour_counter.sv
// Two-digit BCD hours stage: advances 00-23 on carry, issues a day rollover pulse,
// supports range-checked loading; optional 12-hour display under macro HOUR_12_EN.
module hour_counter #(
    parameter int RESET_HOURS = 0
) (
    input  logic          clock,
    input  logic          reset_n,
    hour_counter_if.slave bus
);

    // Out-of-range reset values fall back to midnight.
    localparam logic [4:0] RST_H =
        (RESET_HOURS < 0 || RESET_HOURS > 23) ? 5'd0 : 5'(RESET_HOURS);

    function automatic logic [4:0] disp_hour(input logic [4:0] h);
`ifdef HOUR_12_EN
        if (h == 5'd0)
            return 5'd12;
        else if (h > 5'd12)
            return h - 5'd12;
        else
            return h;
`else
        return h;
`endif
    endfunction

    function automatic logic [1:0] bcd_tens(input logic [4:0] v);
        if (v >= 5'd20)
            return 2'd2;
        else if (v >= 5'd10)
            return 2'd1;
        else
            return 2'd0;
    endfunction

    function automatic logic [3:0] bcd_units(input logic [4:0] v);
        if (v >= 5'd20)
            return 4'(v - 5'd20);
        else if (v >= 5'd10)
            return 4'(v - 5'd10);
        else
            return 4'(v);
    endfunction

    localparam logic [4:0] RST_DISP  = disp_hour(RST_H);
    localparam logic [1:0] RST_TENS  = bcd_tens(RST_DISP);
    localparam logic [3:0] RST_UNITS = bcd_units(RST_DISP);

    logic [4:0] h_q, h_d;
    logic [1:0] tens_q;
    logic [3:0] units_q;
    logic       day_en_q, day_en_d;
    logic       load_err_q, load_err_d;
    logic [5:0] load_val;
    logic       load_ok;
    logic [4:0] disp_d;

    // Widen before multiplying so 3*10+15 cannot overflow the comparison.
    assign load_val = ({4'd0, bus.in_tens} * 6'd10) + {2'd0, bus.in_units};
    assign load_ok  = (bus.in_units <= 4'd9) && (load_val <= 6'd23);

    always_comb begin
        h_d        = h_q;
        day_en_d   = 1'b0;
        load_err_d = 1'b0;
        if (bus.adjust) begin
            if (load_ok)
                h_d = load_val[4:0];
            else
                load_err_d = 1'b1;
        end else if (bus.carry) begin
            if (h_q == 5'd23) begin
                h_d      = 5'd0;
                day_en_d = 1'b1;
            end else begin
                h_d = h_q + 5'd1;
            end
        end
    end

    assign disp_d = disp_hour(h_d);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            h_q        <= RST_H;
            tens_q     <= RST_TENS;
            units_q    <= RST_UNITS;
            day_en_q   <= 1'b0;
            load_err_q <= 1'b0;
        end else begin
            h_q        <= h_d;
            tens_q     <= bcd_tens(disp_d);
            units_q    <= bcd_units(disp_d);
            day_en_q   <= day_en_d;
            load_err_q <= load_err_d;
        end
    end

    assign bus.tens     = tens_q;
    assign bus.units    = units_q;
    assign bus.day_en   = day_en_q;
    assign bus.load_err = load_err_q;

`ifdef HOUR_12_EN
    logic pm_q;

    always_ff @(posedge clock) begin
        if (!reset_n)
            pm_q <= (RST_H >= 5'd12);
        else
            pm_q <= (h_d >= 5'd12);
    end

    assign bus.pm = pm_q;
`endif

endmodule

// File: tb/tb_hour_counter.sv
// Directed bench for hour_counter: reset, counting, rollover, load checking,
// priority and back-to-back carries; 12-hour display when HOUR_12_EN is defined.
module tb_hour_counter;

    logic clock = 1'b0;
    logic reset_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    hour_counter_if bus();

    hour_counter #(.RESET_HOURS(0)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic load(input int t, input int u);
        bus.adjust   = 1'b1;
        bus.in_tens  = 2'(t);
        bus.in_units = 4'(u);
        tick();
        bus.adjust   = 1'b0;
    endtask

    task automatic test_reset();
        int et, eu;
`ifdef HOUR_12_EN
        et = 1; eu = 2;
`else
        et = 0; eu = 0;
`endif
        reset_n = 1'b0;
        bus.carry = 1'b1;
        tick();
        tick();
        checks++;
        if (bus.tens !== 2'(et) || bus.units !== 4'(eu)) begin
            errors++;
            $display("FAIL reset_digits got=%0d%0d exp=%0d%0d", bus.tens, bus.units, et, eu);
        end
        checks++;
        if (bus.day_en !== 1'b0 || bus.load_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags got day_en=%b load_err=%b exp 0/0", bus.day_en, bus.load_err);
        end
`ifdef HOUR_12_EN
        checks++;
        if (bus.pm !== 1'b0) begin
            errors++;
            $display("FAIL reset_pm got=%b exp=0", bus.pm);
        end
`endif
        reset_n = 1'b1;
        bus.carry = 1'b0;
        tick();
        checks++;
        if (bus.tens !== 2'(et) || bus.units !== 4'(eu)) begin
            errors++;
            $display("FAIL idle_hold got=%0d%0d exp=%0d%0d", bus.tens, bus.units, et, eu);
        end
    endtask

    task automatic test_carry_09();
        load(0, 9);
        checks++;
        if (bus.tens !== 2'd0 || bus.units !== 4'd9 || bus.load_err !== 1'b0) begin
            errors++;
            $display("FAIL load_09 got=%0d%0d err=%b exp=09 err=0", bus.tens, bus.units, bus.load_err);
        end
        bus.carry = 1'b1;
        tick();
        bus.carry = 1'b0;
        checks++;
        if (bus.tens !== 2'd1 || bus.units !== 4'd0 || bus.day_en !== 1'b0) begin
            errors++;
            $display("FAIL carry_09 got=%0d%0d day_en=%b exp=10 day_en=0", bus.tens, bus.units, bus.day_en);
        end
        load(1, 9);
        bus.carry = 1'b1;
        tick();
        bus.carry = 1'b0;
        checks++;
        if (bus.tens !== 2'd2 || bus.units !== 4'd0) begin
            errors++;
            $display("FAIL carry_19 got=%0d%0d exp=20", bus.tens, bus.units);
        end
    endtask

    task automatic test_rollover();
        load(2, 3);
        checks++;
        if (bus.tens !== 2'd2 || bus.units !== 4'd3) begin
            errors++;
            $display("FAIL load_23 got=%0d%0d exp=23", bus.tens, bus.units);
        end
        bus.carry = 1'b1;
        tick();
        bus.carry = 1'b0;
        checks++;
        if (bus.tens !== 2'd0 || bus.units !== 4'd0 || bus.day_en !== 1'b1) begin
            errors++;
            $display("FAIL rollover got=%0d%0d day_en=%b exp=00 day_en=1", bus.tens, bus.units, bus.day_en);
        end
        tick();
        checks++;
        if (bus.tens !== 2'd0 || bus.units !== 4'd0 || bus.day_en !== 1'b0) begin
            errors++;
            $display("FAIL rollover_pulse got=%0d%0d day_en=%b exp=00 day_en=0", bus.tens, bus.units, bus.day_en);
        end
    endtask

    task automatic test_illegal_load();
        int bad_t[3] = '{2, 0, 3};
        int bad_u[3] = '{5, 10, 0};
        load(1, 4);
        for (int i = 0; i < 3; i++) begin
            load(bad_t[i], bad_u[i]);
            checks++;
            if (bus.tens !== 2'd1 || bus.units !== 4'd4 || bus.load_err !== 1'b1) begin
                errors++;
                $display("FAIL illegal_load_%0d%0d got=%0d%0d err=%b exp=14 err=1",
                         bad_t[i], bad_u[i], bus.tens, bus.units, bus.load_err);
            end
        end
        tick();
        checks++;
        if (bus.load_err !== 1'b0 || bus.tens !== 2'd1 || bus.units !== 4'd4) begin
            errors++;
            $display("FAIL load_err_pulse got=%0d%0d err=%b exp=14 err=0", bus.tens, bus.units, bus.load_err);
        end
    endtask

    task automatic test_adjust_priority();
        load(0, 5);
        bus.carry = 1'b1;
        load(0, 7);
        bus.carry = 1'b0;
        checks++;
        if (bus.tens !== 2'd0 || bus.units !== 4'd7 || bus.day_en !== 1'b0) begin
            errors++;
            $display("FAIL adjust_over_carry got=%0d%0d day_en=%b exp=07 day_en=0", bus.tens, bus.units, bus.day_en);
        end
        load(2, 3);
        bus.carry = 1'b1;
        load(2, 3);
        bus.carry = 1'b0;
        checks++;
        if (bus.tens !== 2'd2 || bus.units !== 4'd3 || bus.day_en !== 1'b0) begin
            errors++;
            $display("FAIL adjust_at_23 got=%0d%0d day_en=%b exp=23 day_en=0", bus.tens, bus.units, bus.day_en);
        end
    endtask

    task automatic test_reset_override();
        load(2, 2);
        reset_n = 1'b0;
        bus.carry = 1'b1;
        tick();
        reset_n = 1'b1;
        bus.carry = 1'b0;
        checks++;
        if (bus.tens !== 2'd0 || bus.units !== 4'd0 || bus.day_en !== 1'b0) begin
            errors++;
            $display("FAIL reset_override got=%0d%0d day_en=%b exp=00 day_en=0", bus.tens, bus.units, bus.day_en);
        end
    endtask

    task automatic test_back_to_back();
        int day_cnt = 0;
        int exp_h;
        bus.carry = 1'b1;
        for (int i = 1; i <= 30; i++) begin
            tick();
            exp_h = i % 24;
            if (bus.day_en === 1'b1) day_cnt++;
            checks++;
            if (bus.tens !== 2'(exp_h / 10) || bus.units !== 4'(exp_h % 10) ||
                bus.day_en !== (i == 24)) begin
                errors++;
                $display("FAIL b2b_step%0d got=%0d%0d day_en=%b exp=%0d%0d day_en=%b",
                         i, bus.tens, bus.units, bus.day_en, exp_h / 10, exp_h % 10, (i == 24));
            end
        end
        bus.carry = 1'b0;
        checks++;
        if (day_cnt != 1) begin
            errors++;
            $display("FAIL b2b_day_count got=%0d exp=1", day_cnt);
        end
    endtask

`ifdef HOUR_12_EN
    task automatic test_hour_12();
        load(0, 0);
        checks++;
        if (bus.tens !== 2'd1 || bus.units !== 4'd2 || bus.pm !== 1'b0) begin
            errors++;
            $display("FAIL h12_midnight got=%0d%0d pm=%b exp=12 pm=0", bus.tens, bus.units, bus.pm);
        end
        load(1, 1);
        checks++;
        if (bus.tens !== 2'd1 || bus.units !== 4'd1 || bus.pm !== 1'b0) begin
            errors++;
            $display("FAIL h12_11am got=%0d%0d pm=%b exp=11 pm=0", bus.tens, bus.units, bus.pm);
        end
        bus.carry = 1'b1;
        tick();
        bus.carry = 1'b0;
        checks++;
        if (bus.tens !== 2'd1 || bus.units !== 4'd2 || bus.pm !== 1'b1) begin
            errors++;
            $display("FAIL h12_noon got=%0d%0d pm=%b exp=12 pm=1", bus.tens, bus.units, bus.pm);
        end
        load(1, 3);
        checks++;
        if (bus.tens !== 2'd0 || bus.units !== 4'd1 || bus.pm !== 1'b1) begin
            errors++;
            $display("FAIL h12_1pm got=%0d%0d pm=%b exp=01 pm=1", bus.tens, bus.units, bus.pm);
        end
        load(2, 3);
        checks++;
        if (bus.tens !== 2'd1 || bus.units !== 4'd1 || bus.pm !== 1'b1) begin
            errors++;
            $display("FAIL h12_11pm got=%0d%0d pm=%b exp=11 pm=1", bus.tens, bus.units, bus.pm);
        end
        bus.carry = 1'b1;
        tick();
        bus.carry = 1'b0;
        checks++;
        if (bus.tens !== 2'd1 || bus.units !== 4'd2 || bus.pm !== 1'b0 || bus.day_en !== 1'b1) begin
            errors++;
            $display("FAIL h12_rollover got=%0d%0d pm=%b day_en=%b exp=12 pm=0 day_en=1",
                     bus.tens, bus.units, bus.pm, bus.day_en);
        end
    endtask
`endif

    initial begin
        bus.carry    = 1'b0;
        bus.adjust   = 1'b0;
        bus.in_tens  = 2'd0;
        bus.in_units = 4'd0;
        test_reset();
`ifdef HOUR_12_EN
        test_hour_12();
`else
        test_carry_09();
        test_rollover();
        test_illegal_load();
        test_adjust_priority();
        test_reset_override();
        test_back_to_back();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hour_counter.md
# hour_counter

Two-digit BCD hours stage of the digital clock, downstream of the minutes-tens counter. Consumes that counter's one-cycle carry pulse, advances hours 00–23, and issues a one-cycle day-rollover pulse. Supports direct time-set loading from the adjust switches, with range checking, and an optional 12-hour display mode.

## Interface
Parameters:
- RESET_HOURS, default 0: hour value loaded on reset, binary 0–23. Values above 23 are treated as 0.

Ports:
- clock, input, 1: system clock; all state updates on the rising edge.
- reset_n, input, 1: synchronous, active-low reset; sampled on the rising edge of clock.
- carry, input, 1: one-cycle pulse from the minutes-tens stage requesting a one-hour advance.
- adjust, input, 1: 1 = time-set mode; load from in_tens/in_units every cycle.
- in_tens, input, 2: BCD tens digit to load, valid 0–2.
- in_units, input, 4: BCD units digit to load, valid 0–9.
- tens, output, 2: current hours tens digit, BCD, registered.
- units, output, 4: current hours units digit, BCD, registered.
- day_en, output, 1: one-cycle pulse on rollover to the start of the day, registered.
- load_err, output, 1: high for one cycle when an adjust load is rejected, registered.
- pm, output, 1: only present with HOUR_12_EN; 1 = PM, registered.

## Operation
- Internal state: a binary hour register h, range 0–23. The tens, units and pm outputs are derived from h and registered on the same edge that h updates.
- Priority on each edge: reset, then adjust, then carry, then hold.
- Reset (reset_n = 0):
  - h = RESET_HOURS.
  - day_en = 0 and load_err = 0.
  - The outputs show RESET_HOURS on the next cycle.
- Adjust (adjust = 1):
  - A load is legal when in_units ≤ 9 and the value in_tens*10 + in_units ≤ 23.
  - If legal: h takes that value and load_err = 0.
  - If illegal: h holds and load_err = 1 for that cycle.
  - carry is ignored while adjust is high; any carry pulse in that cycle is dropped.
  - day_en = 0 throughout adjust.
- Count (carry = 1, adjust = 0):
  - If h = 23: h becomes 0 and day_en = 1 for exactly one cycle.
  - Otherwise: h becomes h + 1 and day_en = 0.
- Idle: h holds; day_en = 0 and load_err = 0.
- BCD conversion:
  - units = h mod 10, tens = h / 10.
  - Units wrap 9→0 with a tens increment (09→10, 19→20).
  - 23→00 is the only path that wraps tens.
- Consecutive carry pulses (carry high on back-to-back cycles) each advance h by one. No carry is lost or merged.

## Timing
- Latency of one cycle: the carry sampled at edge N is visible on tens/units after edge N.
- day_en is asserted in the same cycle that tens/units first show 00. It is high for exactly one cycle, even if carry stays high.
- An adjust load is visible one cycle after the edge that samples it.
- load_err is coincident with the cycle after the rejected sample.
- reset_n asserted mid-operation overrides everything on that edge. A pending carry is discarded and no day_en is issued.
- Reset values of the outputs:
  - tens/units = RESET_HOURS in BCD.
  - day_en = 0, load_err = 0.
  - pm = (RESET_HOURS ≥ 12).

## Configuration
- Macro HOUR_12_EN.
- Defined:
  - Display digits run 12, 01, 02, …, 11: h = 0 shows 12; h = 13–23 shows h − 12.
  - pm = (h ≥ 12).
  - Adjust inputs remain 24-hour format (00–23).
  - day_en still fires on the 23→0 transition, displayed as 11 PM → 12 AM.
- Undefined:
  - Display is 24-hour (00–23).
  - The pm port is absent.

## Test plan
- Reset with RESET_HOURS = 0, then one carry from 09 → tens=1, units=0 one cycle later; day_en stays 0.
- Load 23 via adjust, drop adjust, pulse carry → display 00 and day_en high for exactly one cycle.
- adjust = 1 with in_tens=2, in_units=5 while displaying 14 → display stays 14; load_err = 1 for one cycle.
- adjust = 1 and carry = 1 in the same cycle with input 07 → display 07 (not 08); day_en = 0.
- Display 22, reset_n = 0 on the same edge as carry → display RESET_HOURS; no day_en. Then 30 back-to-back carries from 00 → display 06 with exactly one day_en pulse.
- HOUR_12_EN: load 00 → 12, pm=0. Load 11 → 11, pm=0; carry → 12, pm=1. Load 23 → 11, pm=1; carry → 12, pm=0, day_en=1.
